fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one `sync_fifo` write port (`wr_en`/`din`/`full`) among `NUM_REQ` producers. Each producer presents data with a valid/ready handshake. The arbiter grants the port to one producer at a time for a bounded burst and stalls cleanly on FIFO full. It sits directly in front of the FIFO's write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 103 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants are bounded bursts; a full FIFO stalls the burst without ending it.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          grant_valid,
    output logic [IW-1:0]                 grant_id
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] grant_nx;
    logic [IW-1:0] last_grant, last_nx;
    logic [7:0]    burst_cnt, cnt_nx;
    logic [IW-1:0] pick;
    logic          pick_ok;
    int            idx;

    // Rotating priority: search upward from the producer after last_grant.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!pick_ok && req_valid[IW'(idx)]) begin
                pick    = IW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_nx;
            grant_id   <= grant_nx;
            last_grant <= last_nx;
            burst_cnt  <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant_id;
        last_nx  = last_grant;
        cnt_nx   = burst_cnt;
        unique case (state)
            IDLE: begin
                if (pick_ok) begin
                    grant_nx = pick;
                    cnt_nx   = '0;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (!req_valid[grant_id]) begin
                    last_nx  = grant_id;
                    state_nx = IDLE;
                end else if (!fifo_full) begin
                    cnt_nx = burst_cnt + 8'd1;
                    if (burst_cnt == 8'(BURST_LEN - 1)) begin
                        last_nx  = grant_id;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake is suppressed during reset so no word is lost in that cycle.
    always_comb begin
        req_ready = '0;
        if (state == BUSY && !rst)
            req_ready[grant_id] = ~fifo_full;
    end

    assign fifo_wr_en  = (state == BUSY) && !rst
                         && req_valid[grant_id] && !fifo_full;
    assign fifo_din    = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign grant_valid = (state == BUSY);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a burst-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BL = 4;

    logic            clock = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_din;
    logic            grant_valid;
    logic [1:0]      grant_id;

    always #5 clock = ~clock;

    fifo_wr_arbiter #(
        .NUM_REQ(N),
        .DATA_WIDTH(DW),
        .BURST_LEN(BL)
    ) dut (
        .clock(clock),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din),
        .grant_valid(grant_valid),
        .grant_id(grant_id)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic        f;
        logic [15:0] d0;
        logic        wr;
        logic [15:0] din;
        logic [3:0]  rdy;
        logic        gv;
        logic [1:0]  gid;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic r, input logic [3:0] v, input logic f,
                        input logic [15:0] d0, input logic wr,
                        input logic [15:0] din, input logic [3:0] rdy,
                        input logic gv, input logic [1:0] gid);
        vec_t t;
        t.r = r; t.v = v; t.f = f; t.d0 = d0; t.wr = wr;
        t.din = din; t.rdy = rdy; t.gv = gv; t.gid = gid;
        tbl.push_back(t);
    endtask

    // Reference model: who holds the port and how many words it has sent.
    int m_cur, m_cnt, m_last, m_gid;
    logic [11:0] seq [N];
    logic        s_wr, s_gv;
    logic [1:0]  s_gid;
    logic [3:0]  s_rdy;
    logic [15:0] s_din;

    task automatic step(input bit docheck);
        logic        e_wr, e_gv;
        logic [3:0]  e_rdy;
        logic [15:0] e_din;
        for (int i = 0; i < N; i++)
            req_data[i*DW +: DW] = {4'(i), seq[i]};
        #4;
        e_gv  = (m_cur >= 0);
        e_rdy = '0;
        e_wr  = 1'b0;
        e_din = '0;
        if (!rst && m_cur >= 0) begin
            e_rdy = fifo_full ? 4'b0 : 4'(1 << m_cur);
            e_wr  = req_valid[m_cur] & ~fifo_full;
            e_din = {4'(m_cur), seq[m_cur]};
        end
        if (docheck) begin
            chk("grant_valid", 32'(grant_valid), 32'(e_gv));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
            if (e_wr) chk("fifo_din", 32'(fifo_din), 32'(e_din));
        end
        s_wr  = fifo_wr_en;
        s_gv  = grant_valid;
        s_gid = grant_id;
        s_rdy = req_ready;
        s_din = fifo_din;
        @(posedge clock);
        if (rst) begin
            m_cur = -1; m_cnt = 0; m_last = N - 1; m_gid = 0;
        end else if (m_cur < 0) begin
            for (int k = 1; k <= N; k++) begin
                int w;
                w = (m_last + k) % N;
                if (m_cur < 0 && req_valid[w]) begin
                    m_cur = w; m_gid = w; m_cnt = 0;
                end
            end
        end else if (!req_valid[m_cur]) begin
            m_last = m_cur;
            m_cur  = -1;
        end else if (!fifo_full) begin
            m_cnt++;
            if (m_cnt == BL) begin
                m_last = m_cur;
                m_cur  = -1;
            end
        end
        for (int i = 0; i < N; i++)
            if (req_valid[i] && s_rdy[i]) seq[i]++;
        #1;
    endtask

    initial begin
        int          gl[$];
        int          wc[$];
        logic [15:0] q[$];
        logic        prev_gv;
        int          n_idle;
        int          nw;
        logic [11:0] base;

        m_cur = -1; m_cnt = 0; m_last = N - 1; m_gid = 0;
        for (int i = 0; i < N; i++) seq[i] = '0;
        rst = 1'b1; req_valid = '0; fifo_full = 1'b0; req_data = '0;
        @(posedge clock);
        #1;

        // Directed table: reset/idle, then single producer 0.
        for (int i = 0; i < 10; i++)
            addv(1, 4'h0, 0, 16'h0, 0, 16'h0, 4'h0, 0, 2'd0);
        for (int i = 0; i < 3; i++)
            addv(0, 4'h0, 0, 16'h0, 0, 16'h0, 4'h0, 0, 2'd0);
        addv(0, 4'h1, 0, 16'h1000, 0, 16'h0,    4'h0, 0, 2'd0);
        addv(0, 4'h1, 0, 16'h1000, 1, 16'h1000, 4'h1, 1, 2'd0);
        addv(0, 4'h1, 0, 16'h1001, 1, 16'h1001, 4'h1, 1, 2'd0);
        addv(0, 4'h1, 0, 16'h1002, 1, 16'h1002, 4'h1, 1, 2'd0);
        addv(0, 4'h1, 0, 16'h1003, 1, 16'h1003, 4'h1, 1, 2'd0);
        addv(0, 4'h1, 0, 16'h1004, 0, 16'h0,    4'h0, 0, 2'd0);
        addv(0, 4'h1, 0, 16'h1004, 1, 16'h1004, 4'h1, 1, 2'd0);
        addv(0, 4'h1, 0, 16'h1005, 1, 16'h1005, 4'h1, 1, 2'd0);
        addv(0, 4'h0, 0, 16'h0,    0, 16'h0,    4'h1, 1, 2'd0);
        addv(0, 4'h0, 0, 16'h0,    0, 16'h0,    4'h0, 0, 2'd0);

        foreach (tbl[i]) begin
            rst = tbl[i].r;
            req_valid = tbl[i].v;
            fifo_full = tbl[i].f;
            req_data = '0;
            req_data[DW-1:0] = tbl[i].d0;
            #4;
            chk("tbl_wr_en", 32'(fifo_wr_en), 32'(tbl[i].wr));
            chk("tbl_ready", 32'(req_ready), 32'(tbl[i].rdy));
            chk("tbl_gvalid", 32'(grant_valid), 32'(tbl[i].gv));
            chk("tbl_gid", 32'(grant_id), 32'(tbl[i].gid));
            if (tbl[i].wr) chk("tbl_din", 32'(fifo_din), 32'(tbl[i].din));
            @(posedge clock);
            #1;
        end

        // Resynchronise the model with the DUT.
        rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
        step(0);
        rst = 1'b0;

        // Round-robin with all producers valid.
        req_valid = 4'hF;
        prev_gv = 1'b0;
        n_idle = 0;
        for (int c = 0; c < 25; c++) begin
            step(1);
            if (s_gv && !prev_gv) begin
                gl.push_back(int'(s_gid));
                wc.push_back(0);
            end
            if (s_wr && wc.size() > 0) wc[wc.size()-1]++;
            if (c > 0 && !s_gv) n_idle++;
            prev_gv = s_gv;
        end
        chk("rr_ngrants", 32'(gl.size()), 32'd5);
        chk("rr_idle", 32'(n_idle), 32'd4);
        for (int k = 0; k < 5; k++)
            if (k < gl.size()) chk("rr_order", 32'(gl[k]), 32'(k % N));
        for (int k = 0; k < 4; k++)
            if (k < wc.size()) chk("rr_words", 32'(wc[k]), 32'(BL));

        // Full stall in the middle of producer 2's burst.
        req_valid = '0; rst = 1'b1;
        step(1);
        rst = 1'b0;
        req_valid = 4'b0100;
        base = seq[2];
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            step(1);
            if (s_wr) q.push_back(s_din);
            if (fifo_full) begin
                chk("stall_ready", 32'(s_rdy[2]), 32'd0);
                chk("stall_wr", 32'(s_wr), 32'd0);
            end
            if (c == 8) chk("stall_end", 32'(s_gv), 32'd0);
        end
        fifo_full = 1'b0;
        chk("stall_nwords", 32'(q.size()), 32'd4);
        foreach (q[k])
            chk("stall_word", 32'(q[k]), 32'({4'd2, 12'(base + 12'(k))}));

        // Early release by producer 1 while producer 3 waits.
        req_valid = '0; rst = 1'b1;
        step(1);
        rst = 1'b0;
        req_valid = 4'b0010;
        step(1);
        step(1);
        step(1);
        req_valid = 4'b1000;
        step(1);
        chk("rel_gid", 32'(s_gid), 32'd1);
        chk("rel_last", 32'(dut.last_grant), 32'd1);
        step(1);
        chk("rel_idle", 32'(s_gv), 32'd0);
        step(1);
        chk("rel_grant3", 32'({s_gv, s_gid}), 32'({1'b1, 2'd3}));
        req_valid = '0;
        step(1);
        step(1);

        // Reset in the middle of producer 0's burst.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req_valid = 4'b0001;
        nw = 0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            if (s_wr) nw++;
        end
        rst = 1'b1;
        step(1);
        chk("rst_no_wr", 32'(s_wr), 32'd0);
        if (s_wr) nw++;
        chk("rst_words", 32'(nw), 32'd2);
        rst = 1'b0;
        req_valid = 4'hF;
        step(1);
        chk("rst_idle", 32'(s_gv), 32'd0);
        step(1);
        chk("rst_prio0", 32'({s_gv, s_gid}), 32'({1'b1, 2'd0}));

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            req_valid = 4'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 63) == 0);
            step(1);
        end
        rst = 1'b0; req_valid = '0; fifo_full = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
